// File: rtl/wb_stream_pkt_fifo.sv
// FWFT stream FIFO with per-word last flag, optional store-and-forward packet mode,
// synchronous flush, programmable almost-full/almost-empty and fill/packet counters.
module wb_stream_pkt_fifo #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 4,
  parameter bit          PKT_MODE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [AW:0]   af_thresh_i,
  input  logic [AW:0]   ae_thresh_i,
  output logic [AW:0]   cnt,
  output logic [AW:0]   pkt_cnt_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  input  logic [DW-1:0] stream_s_data_i,
  input  logic          stream_s_last_i,
  input  logic          stream_s_valid_i,
  output logic          stream_s_ready_o,
  output logic [DW-1:0] stream_m_data_o,
  output logic          stream_m_last_o,
  output logic          stream_m_valid_o,
  input  logic          stream_m_ready_i
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          is_full;
  logic          pkt_ok;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;

  // Full/empty come from cnt, so pointers may simply wrap.
  assign is_full = (cnt == CW'(DEPTH));

  // Full override keeps packets longer than the depth from deadlocking.
  assign pkt_ok = PKT_MODE ? ((pkt_cnt_o != '0) | is_full) : 1'b1;

  assign stream_s_ready_o = !is_full & !flush_i;
  assign stream_m_valid_o = (cnt != '0) & !flush_i & pkt_ok;

  assign wr_en   = stream_s_valid_i & stream_s_ready_o;
  assign rd_en   = stream_m_valid_o & stream_m_ready_i;
  assign wr_last = wr_en & stream_s_last_i;
  assign rd_last = rd_en & stream_m_last_o;

  assign {stream_m_last_o, stream_m_data_o} = mem[rd_ptr];

  assign almost_full_o  = (cnt >= af_thresh_i);
  assign almost_empty_o = (cnt <= ae_thresh_i);

  // Storage; reset clears it so the output word reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= {stream_s_last_i, stream_s_data_i};
    end
  end

  // Pointers and counters; flush outranks every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      pkt_cnt_o <= '0;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      pkt_cnt_o <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      case ({wr_last, rd_last})
        2'b10:   pkt_cnt_o <= pkt_cnt_o + CW'(1);
        2'b01:   pkt_cnt_o <= pkt_cnt_o - CW'(1);
        default: pkt_cnt_o <= pkt_cnt_o;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_pkt_fifo.sv
// Scoreboard bench for wb_stream_pkt_fifo: word-mode AW=2 (a), packet-mode AW=3 (b)
// and packet-mode AW=2 (c) instances driven from one sequence of scenario tasks.
module tb_wb_stream_pkt_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic       fl_a, afo_a, aeo_a, sl_a, sv_a, sr_a, ml_a, mv_a, mr_a;
  logic [2:0] af_a, ae_a, cnt_a, pc_a;
  logic [7:0] sd_a, md_a;
  logic       fl_b, afo_b, aeo_b, sl_b, sv_b, sr_b, ml_b, mv_b, mr_b;
  logic [3:0] af_b, ae_b, cnt_b, pc_b;
  logic [7:0] sd_b, md_b;
  logic       fl_c, afo_c, aeo_c, sl_c, sv_c, sr_c, ml_c, mv_c, mr_c;
  logic [2:0] af_c, ae_c, cnt_c, pc_c;
  logic [7:0] sd_c, md_c;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] q_c[$];

  wb_stream_pkt_fifo #(.DW(8), .AW(2), .PKT_MODE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_a), .af_thresh_i(af_a), .ae_thresh_i(ae_a),
    .cnt(cnt_a), .pkt_cnt_o(pc_a), .almost_full_o(afo_a), .almost_empty_o(aeo_a),
    .stream_s_data_i(sd_a), .stream_s_last_i(sl_a), .stream_s_valid_i(sv_a),
    .stream_s_ready_o(sr_a), .stream_m_data_o(md_a), .stream_m_last_o(ml_a),
    .stream_m_valid_o(mv_a), .stream_m_ready_i(mr_a));

  wb_stream_pkt_fifo #(.DW(8), .AW(3), .PKT_MODE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_b), .af_thresh_i(af_b), .ae_thresh_i(ae_b),
    .cnt(cnt_b), .pkt_cnt_o(pc_b), .almost_full_o(afo_b), .almost_empty_o(aeo_b),
    .stream_s_data_i(sd_b), .stream_s_last_i(sl_b), .stream_s_valid_i(sv_b),
    .stream_s_ready_o(sr_b), .stream_m_data_o(md_b), .stream_m_last_o(ml_b),
    .stream_m_valid_o(mv_b), .stream_m_ready_i(mr_b));

  wb_stream_pkt_fifo #(.DW(8), .AW(2), .PKT_MODE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_c), .af_thresh_i(af_c), .ae_thresh_i(ae_c),
    .cnt(cnt_c), .pkt_cnt_o(pc_c), .almost_full_o(afo_c), .almost_empty_o(aeo_c),
    .stream_s_data_i(sd_c), .stream_s_last_i(sl_c), .stream_s_valid_i(sv_c),
    .stream_s_ready_o(sr_c), .stream_m_data_o(md_c), .stream_m_last_o(ml_c),
    .stream_m_valid_o(mv_c), .stream_m_ready_i(mr_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (cnt_a !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    n_cmp++; if (pc_a !== 3'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d want 0", pc_a); end
    n_cmp++; if (mv_a !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", mv_a); end
    n_cmp++; if ({ml_a, md_a} !== 9'h000) begin n_bad++; $display("FAIL reset_m_data: got %h want 000", {ml_a, md_a}); end
    n_cmp++; if (aeo_a !== 1'b1) begin n_bad++; $display("FAIL reset_almost_empty: got %b want 1", aeo_a); end
    n_cmp++; if (mv_b !== 1'b0 || mv_c !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid_bc: got %b%b want 00", mv_b, mv_c); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (sr_a !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", sr_a); end
  endtask

  task automatic test_fill_drain();
    logic [8:0] e;
    mr_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sv_a = 1'b1; sd_a = 8'(8'h11 * (i + 1)); sl_a = (i == 3);
      #1;
      n_cmp++; if (sr_a !== 1'b1) begin n_bad++; $display("FAIL fill_s_ready[%0d]: got %b want 1", i, sr_a); end
      q_a.push_back({sl_a, sd_a});
      tick();
    end
    sv_a = 1'b1; sd_a = 8'h55; sl_a = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 3'd4) begin n_bad++; $display("FAIL full_cnt: got %0d want 4", cnt_a); end
    n_cmp++; if (sr_a !== 1'b0) begin n_bad++; $display("FAIL full_s_ready: got %b want 0", sr_a); end
    tick();
    sv_a = 1'b0; mr_a = 1'b1;
    #1;
    n_cmp++; if (cnt_a !== 3'd4) begin n_bad++; $display("FAIL refused_cnt: got %0d want 4", cnt_a); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mv_a !== 1'b1) begin n_bad++; $display("FAIL drain_m_valid[%0d]: got %b want 1", i, mv_a); end
      e = (q_a.size() != 0) ? q_a.pop_front() : 9'h1FF;
      n_cmp++; if ({ml_a, md_a} !== e) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, {ml_a, md_a}, e); end
      tick();
      #1;
    end
    n_cmp++; if (mv_a !== 1'b0) begin n_bad++; $display("FAIL drained_m_valid: got %b want 0", mv_a); end
    n_cmp++; if (cnt_a !== 3'd0) begin n_bad++; $display("FAIL drained_cnt: got %0d want 0", cnt_a); end
    mr_a = 1'b0;
  endtask

  task automatic test_fwft();
    logic [8:0] e;
    mr_a = 1'b1; sv_a = 1'b1; sd_a = 8'hA5; sl_a = 1'b0;
    #1;
    n_cmp++; if (mv_a !== 1'b0) begin n_bad++; $display("FAIL fwft_bypass: got %b want 0", mv_a); end
    q_a.push_back({sl_a, sd_a});
    tick();
    sv_a = 1'b0;
    #1;
    n_cmp++; if (mv_a !== 1'b1) begin n_bad++; $display("FAIL fwft_m_valid: got %b want 1", mv_a); end
    e = (q_a.size() != 0) ? q_a.pop_front() : 9'h1FF;
    n_cmp++; if ({ml_a, md_a} !== e) begin n_bad++; $display("FAIL fwft_data: got %h want %h", {ml_a, md_a}, e); end
    n_cmp++; if (cnt_a !== 3'd1) begin n_bad++; $display("FAIL fwft_cnt1: got %0d want 1", cnt_a); end
    tick();
    #1;
    n_cmp++; if (cnt_a !== 3'd0) begin n_bad++; $display("FAIL fwft_cnt0: got %0d want 0", cnt_a); end
    n_cmp++; if (mv_a !== 1'b0) begin n_bad++; $display("FAIL fwft_empty_valid: got %b want 0", mv_a); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    mr_a = 1'b1; sv_a = 1'b1; sd_a = 8'h00; sl_a = 1'b0;
    q_a.push_back({sl_a, sd_a});
    tick();
    for (int i = 1; i <= 100; i++) begin
      sd_a = 8'(i); sl_a = ((i % 7) == 0);
      #1;
      n_cmp++; if (mv_a !== 1'b1 || cnt_a !== 3'd1) begin n_bad++; $display("FAIL b2b_state[%0d]: got valid=%b cnt=%0d want valid=1 cnt=1", i, mv_a, cnt_a); end
      e = (q_a.size() != 0) ? q_a.pop_front() : 9'h1FF;
      n_cmp++; if ({ml_a, md_a} !== e) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, {ml_a, md_a}, e); end
      n_cmp++; if (pc_a !== 3'(e[8])) begin n_bad++; $display("FAIL b2b_pkt_cnt[%0d]: got %0d want %0d", i, pc_a, e[8]); end
      q_a.push_back({sl_a, sd_a});
      tick();
    end
    sv_a = 1'b0;
    #1;
    e = (q_a.size() != 0) ? q_a.pop_front() : 9'h1FF;
    n_cmp++; if (mv_a !== 1'b1 || {ml_a, md_a} !== e) begin n_bad++; $display("FAIL b2b_tail: got valid=%b %h want valid=1 %h", mv_a, {ml_a, md_a}, e); end
    tick();
    #1;
    n_cmp++; if (cnt_a !== 3'd0) begin n_bad++; $display("FAIL b2b_end_cnt: got %0d want 0", cnt_a); end
    mr_a = 1'b0;
  endtask

  task automatic test_thresholds();
    af_a = 3'd3; ae_a = 3'd1; mr_a = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      sv_a = (k < 4); sd_a = 8'(8'h60 + k); sl_a = (k == 2);
      #1;
      n_cmp++; if (cnt_a !== 3'(k)) begin n_bad++; $display("FAIL thr_cnt[%0d]: got %0d want %0d", k, cnt_a, k); end
      n_cmp++; if (aeo_a !== (k <= 1)) begin n_bad++; $display("FAIL thr_ae[%0d]: got %b want %b", k, aeo_a, (k <= 1)); end
      n_cmp++; if (afo_a !== (k >= 3)) begin n_bad++; $display("FAIL thr_af[%0d]: got %b want %b", k, afo_a, (k >= 3)); end
      if (k < 4) q_a.push_back({sl_a, sd_a});
      tick();
    end
    af_a = 3'd5;
    #1;
    n_cmp++; if (afo_a !== 1'b0) begin n_bad++; $display("FAIL thr_af_above_depth: got %b want 0", afo_a); end
    af_a = 3'd0; ae_a = 3'd4;
    #1;
    n_cmp++; if (afo_a !== 1'b1 || aeo_a !== 1'b1) begin n_bad++; $display("FAIL thr_zero_and_max: got af=%b ae=%b want 1 1", afo_a, aeo_a); end
    af_a = 3'd3; ae_a = 3'd1;
  endtask

  task automatic test_flush();
    logic [8:0] e;
    mr_a = 1'b1; sv_a = 1'b0;
    #1;
    e = (q_a.size() != 0) ? q_a.pop_front() : 9'h1FF;
    n_cmp++; if (mv_a !== 1'b1 || {ml_a, md_a} !== e) begin n_bad++; $display("FAIL flush_pre_read: got valid=%b %h want valid=1 %h", mv_a, {ml_a, md_a}, e); end
    tick();
    n_cmp++; if (cnt_a !== 3'd3 || pc_a !== 3'd1) begin n_bad++; $display("FAIL flush_pre_state: got cnt=%0d pkt=%0d want 3 1", cnt_a, pc_a); end
    fl_a = 1'b1; sv_a = 1'b1; sd_a = 8'hEE; sl_a = 1'b1;
    #1;
    n_cmp++; if (sr_a !== 1'b0 || mv_a !== 1'b0) begin n_bad++; $display("FAIL flush_handshake: got ready=%b valid=%b want 0 0", sr_a, mv_a); end
    tick();
    fl_a = 1'b0; sv_a = 1'b0; mr_a = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 3'd0 || pc_a !== 3'd0 || mv_a !== 1'b0) begin n_bad++; $display("FAIL flush_after: got cnt=%0d pkt=%0d valid=%b want 0 0 0", cnt_a, pc_a, mv_a); end
    q_a.delete();
    fl_a = 1'b1; sv_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (cnt_a !== 3'd0 || sr_a !== 1'b0 || mv_a !== 1'b0) begin n_bad++; $display("FAIL flush_held[%0d]: got cnt=%0d ready=%b valid=%b want 0 0 0", i, cnt_a, sr_a, mv_a); end
      tick();
    end
    fl_a = 1'b0; sv_a = 1'b0; sl_a = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 3'd0 || sr_a !== 1'b1) begin n_bad++; $display("FAIL flush_release: got cnt=%0d ready=%b want 0 1", cnt_a, sr_a); end
  endtask

  task automatic test_pkt_store();
    logic [8:0] e;
    mr_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sv_b = 1'b1; sd_b = 8'(8'hB0 + i); sl_b = (i == 2);
      #1;
      n_cmp++; if (mv_b !== 1'b0) begin n_bad++; $display("FAIL pkt_hold_valid[%0d]: got %b want 0", i, mv_b); end
      q_b.push_back({sl_b, sd_b});
      tick();
    end
    sv_b = 1'b0; sl_b = 1'b0;
    #1;
    n_cmp++; if (pc_b !== 4'd1) begin n_bad++; $display("FAIL pkt_cnt_one: got %0d want 1", pc_b); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mv_b !== 1'b1) begin n_bad++; $display("FAIL pkt_out_valid[%0d]: got %b want 1", i, mv_b); end
      e = (q_b.size() != 0) ? q_b.pop_front() : 9'h1FF;
      n_cmp++; if ({ml_b, md_b} !== e) begin n_bad++; $display("FAIL pkt_out_data[%0d]: got %h want %h", i, {ml_b, md_b}, e); end
      tick();
      #1;
    end
    n_cmp++; if (pc_b !== 4'd0 || mv_b !== 1'b0 || cnt_b !== 4'd0) begin n_bad++; $display("FAIL pkt_end: got pkt=%0d valid=%b cnt=%0d want 0 0 0", pc_b, mv_b, cnt_b); end
    mr_b = 1'b0;
  endtask

  task automatic test_pkt_override();
    logic [8:0] e;
    int wi = 0;
    int ri = 0;
    int mc = 0;
    int mp = 0;
    bit esr, emv, wr;
    mr_c = 1'b1;
    for (int cyc = 0; cyc < 60 && ri < 6; cyc++) begin
      sv_c = (wi < 6); sd_c = 8'(8'hC0 + wi); sl_c = (wi == 5);
      #1;
      esr = (mc != 4);
      emv = (mc != 0) && (mp != 0 || mc == 4);
      n_cmp++; if (sr_c !== esr || mv_c !== emv) begin n_bad++; $display("FAIL ovr_hs[%0d]: got ready=%b valid=%b want %b %b", cyc, sr_c, mv_c, esr, emv); end
      n_cmp++; if (cnt_c !== 3'(mc) || pc_c !== 3'(mp)) begin n_bad++; $display("FAIL ovr_cnt[%0d]: got cnt=%0d pkt=%0d want %0d %0d", cyc, cnt_c, pc_c, mc, mp); end
      wr = sv_c && esr;
      if (emv) begin
        e = (q_c.size() != 0) ? q_c.pop_front() : 9'h1FF;
        n_cmp++; if ({ml_c, md_c} !== e) begin n_bad++; $display("FAIL ovr_data[%0d]: got %h want %h", ri, {ml_c, md_c}, e); end
        if (e[8]) mp--;
        ri++;
      end
      if (wr) begin
        q_c.push_back({sl_c, sd_c});
        if (sl_c) mp++;
        wi++;
      end
      mc = mc + int'(wr) - int'(emv);
      tick();
    end
    sv_c = 1'b0; sl_c = 1'b0;
    #1;
    n_cmp++; if (cnt_c !== 3'd0 || sr_c !== 1'b1 || pc_c !== 3'd0) begin n_bad++; $display("FAIL ovr_end: got cnt=%0d ready=%b pkt=%0d want 0 1 0", cnt_c, sr_c, pc_c); end
    mr_c = 1'b0;
  endtask

  task automatic test_async_reset();
    mr_a = 1'b0; sv_a = 1'b1; sd_a = 8'h77; sl_a = 1'b1;
    tick();
    tick();
    sv_a = 1'b0;
    n_cmp++; if (cnt_a !== 3'd2 || pc_a !== 3'd2) begin n_bad++; $display("FAIL arst_pre: got cnt=%0d pkt=%0d want 2 2", cnt_a, pc_a); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 3'd0 || pc_a !== 3'd0) begin n_bad++; $display("FAIL arst_cnt: got cnt=%0d pkt=%0d want 0 0", cnt_a, pc_a); end
    n_cmp++; if (mv_a !== 1'b0 || {ml_a, md_a} !== 9'h000) begin n_bad++; $display("FAIL arst_out: got valid=%b %h want 0 000", mv_a, {ml_a, md_a}); end
    n_cmp++; if (aeo_a !== 1'b1) begin n_bad++; $display("FAIL arst_ae: got %b want 1", aeo_a); end
    tick();
    rst_n = 1'b1;
    q_a.delete();
    #1;
    n_cmp++; if (sr_a !== 1'b1 || mv_a !== 1'b0) begin n_bad++; $display("FAIL arst_release: got ready=%b valid=%b want 1 0", sr_a, mv_a); end
  endtask

  initial begin
    fl_a = 1'b0; af_a = 3'd3; ae_a = 3'd1; sd_a = '0; sl_a = 1'b0; sv_a = 1'b0; mr_a = 1'b0;
    fl_b = 1'b0; af_b = 4'd8; ae_b = 4'd0; sd_b = '0; sl_b = 1'b0; sv_b = 1'b0; mr_b = 1'b0;
    fl_c = 1'b0; af_c = 3'd4; ae_c = 3'd0; sd_c = '0; sl_c = 1'b0; sv_c = 1'b0; mr_c = 1'b0;
    test_reset();
    test_fill_drain();
    test_fwft();
    test_back_to_back();
    test_thresholds();
    test_flush();
    test_pkt_store();
    test_pkt_override();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
